mdu_controller: RTL

MDU_CONTROLLER -- requirements
Module: mdu_controller

---
 rtl/settings.sv | 33 +++
 rtl/mdu_divider.sv | 76 +++++++
 rtl/mdu_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/settings.sv
// Shared MDU settings: operation encodings, FSM state encoding, division length
// and the multiply helper used by mdu_controller and mdu_divider.
package settings;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mduOp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mduState_t;

    localparam int MDU_DIV_CYCLES = 32;

    // Sign-extends to 64 bits when signed so one unsigned multiply covers both forms.
    function automatic logic [63:0] mulProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// 32-cycle restoring divider on operand magnitudes; signs are reapplied on the
// final cycle, where valid=1 and quotient/remainder already hold the result.
module mdu_divider
    import settings::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        isSigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [5:0]  count;
    logic [31:0] remReg;
    logic [31:0] quoReg;
    logic [31:0] divisorMag;
    logic [31:0] dividendRaw;
    logic        negQ;
    logic        negR;
    logic        divZero;
    logic        negA;
    logic        negB;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] remStep;
    logic [31:0] quoStep;

    assign negA = isSigned & dividend[31];
    assign negB = isSigned & divisor[31];

    always_comb begin
        shifted = {remReg, quoReg[31]};
        fits    = shifted >= {1'b0, divisorMag};
        remStep = fits ? 32'(shifted - {1'b0, divisorMag}) : shifted[31:0];
        quoStep = {quoReg[30:0], fits};
    end

    // The last iteration is combinational so the result lands on the 32nd busy edge.
    assign valid     = (count == 6'd1);
    assign quotient  = divZero ? 32'hFFFF_FFFF : (negQ ? -quoStep : quoStep);
    assign remainder = divZero ? dividendRaw   : (negR ? -remStep : remStep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            divisorMag  <= '0;
            dividendRaw <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            divZero     <= 1'b0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            count       <= 6'(MDU_DIV_CYCLES);
            remReg      <= '0;
            quoReg      <= negA ? -dividend : dividend;
            divisorMag  <= negB ? -divisor : divisor;
            dividendRaw <= dividend;
            negQ        <= negA ^ negB;
            negR        <= negA;
            divZero     <= (divisor == 32'd0);
        end else if (count != 6'd0) begin
            count  <= count - 6'd1;
            remReg <= remStep;
            quoReg <= quoStep;
        end
    end

endmodule

// File: rtl/mdu_controller.sv
// MIPS HI/LO multiply-divide unit controller. Define MDU_FAST_MULT_EN for
// single-cycle MULT/MULTU; otherwise multiplies stay busy MULT_LATENCY cycles.
module mdu_controller
    import settings::*;
#(
    parameter int MULT_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mduState_t   dbgState
);

    // Handshake: start is taken only in IDLE/DONE with flush low; while busy=1 the
    // hazard unit holds the pipeline and any start is dropped; done pulses for one
    // cycle when the new HI/LO becomes visible.
    mduState_t   state;
    mduState_t   nextState;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] hiNext;
    logic [31:0] loNext;
    logic        loadMul;
    logic        divStart;
    logic        divAbort;
    logic        divValid;
    logic [31:0] divQuo;
    logic [31:0] divRem;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mulSigned;
    logic [4:0]  mulCount;
    logic [63:0] product;

`ifdef MDU_FAST_MULT_EN
    assign product = mulProduct(rs_val, rt_val, op == MDU_MULT);
`else
    assign product = mulProduct(opA, opB, mulSigned);
`endif

    mdu_divider uDivider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (divStart),
        .abort    (divAbort),
        .isSigned (op == MDU_DIV),
        .dividend (rs_val),
        .divisor  (rt_val),
        .valid    (divValid),
        .quotient (divQuo),
        .remainder(divRem)
    );

    always_comb begin
        nextState = state;
        writeHi   = 1'b0;
        writeLo   = 1'b0;
        hiNext    = hi;
        loNext    = lo;
        loadMul   = 1'b0;
        divStart  = 1'b0;
        divAbort  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                nextState = ST_IDLE;
                if (start && !flush) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                            writeHi   = 1'b1;
                            writeLo   = 1'b1;
                            hiNext    = product[63:32];
                            loNext    = product[31:0];
                            nextState = ST_DONE;
`else
                            loadMul   = 1'b1;
                            nextState = ST_MUL;
`endif
                        end
                        MDU_DIV, MDU_DIVU: begin
                            divStart  = 1'b1;
                            nextState = ST_DIV;
                        end
                        MDU_MTHI: begin
                            writeHi = 1'b1;
                            hiNext  = rs_val;
                        end
                        MDU_MTLO: begin
                            writeLo = 1'b1;
                            loNext  = rs_val;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    nextState = ST_IDLE;
                end else if (mulCount == 5'd0) begin
                    writeHi   = 1'b1;
                    writeLo   = 1'b1;
                    hiNext    = product[63:32];
                    loNext    = product[31:0];
                    nextState = ST_DONE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    divAbort  = 1'b1;
                    nextState = ST_IDLE;
                end else if (divValid) begin
                    writeHi   = 1'b1;
                    writeLo   = 1'b1;
                    hiNext    = divRem;
                    loNext    = divQuo;
                    nextState = ST_DONE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hi        <= '0;
            lo        <= '0;
            opA       <= '0;
            opB       <= '0;
            mulSigned <= 1'b0;
            mulCount  <= '0;
        end else begin
            state <= nextState;
            if (writeHi) hi <= hiNext;
            if (writeLo) lo <= loNext;
            if (loadMul) begin
                opA       <= rs_val;
                opB       <= rt_val;
                mulSigned <= (op == MDU_MULT);
                mulCount  <= 5'(MULT_LATENCY - 1);
            end else if (state == ST_MUL) begin
                mulCount <= (flush || mulCount == 5'd0) ? 5'd0 : mulCount - 5'd1;
            end
        end
    end

    assign busy     = (state == ST_MUL) || (state == ST_DIV);
    assign done     = (state == ST_DONE);
    assign dbgState = state;

endmodule
